// File: rtl/lbm_stream_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lbm_pkg
//  Purpose  : Shared D2Q9 lattice constants, sequencer state encoding and the
//             ping-pong memory address helper.
//  Contents : Q_D2Q9, CX/CY velocity tables, OPP opposite-direction table,
//             state_t, mem_addr().
//  Revision : 1.0 - initial parametrised release
// ============================================================================
package lbm_pkg;

  localparam int Q_D2Q9 = 9;

  typedef logic signed [1:0] vel_t;

  // Direction order: 0 rest, 1 E, 2 N, 3 W, 4 S, 5 NE, 6 NW, 7 SW, 8 SE
  localparam vel_t CX [Q_D2Q9] = '{2'sd0, 2'sd1, 2'sd0, -2'sd1, 2'sd0,
                                   2'sd1, -2'sd1, -2'sd1, 2'sd1};
  localparam vel_t CY [Q_D2Q9] = '{2'sd0, 2'sd0, 2'sd1, 2'sd0, -2'sd1,
                                   2'sd1, 2'sd1, -2'sd1, -2'sd1};
  localparam int OPP [Q_D2Q9] = '{0, 3, 4, 1, 2, 7, 8, 5, 6};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SWEEP    = 2'd1,
    STEP_END = 2'd2,
    DONE     = 2'd3
  } state_t;

  // {buffer bit, y*nx + x}; the buffer bit lands at bit position aw.
  function automatic logic [31:0] mem_addr(input logic buf_bit,
                                           input int unsigned x,
                                           input int unsigned y,
                                           input int unsigned nx,
                                           input int unsigned aw);
    logic [31:0] idx;
    idx = y * nx + x;
    return (32'(buf_bit) << aw) | idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lbm_stream_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : lbm_stream_sequencer_if
//  Purpose  : Per-cell output word and valid/ready handshake between the
//             stream sequencer (master) and the collision datapath (slave).
//  Signals  : valid_out, ready_in, cell_addr, stream_addr, bounce,
//             LID, BOTTOM_WALL, LEFT_WALL, RIGHT_WALL
//  Revision : 1.0 - initial parametrised release
// ============================================================================
interface lbm_stream_sequencer_if #(
  parameter int AW2 = 9,
  parameter int Q   = 9
);
  logic             valid_out;
  logic             ready_in;
  logic [AW2-1:0]   cell_addr;
  logic [Q*AW2-1:0] stream_addr;
  logic [Q-1:0]     bounce;
  logic             LID;
  logic             BOTTOM_WALL;
  logic             LEFT_WALL;
  logic             RIGHT_WALL;

  modport master (
    output valid_out, cell_addr, stream_addr, bounce,
           LID, BOTTOM_WALL, LEFT_WALL, RIGHT_WALL,
    input  ready_in
  );

  modport slave (
    input  valid_out, cell_addr, stream_addr, bounce,
           LID, BOTTOM_WALL, LEFT_WALL, RIGHT_WALL,
    output ready_in
  );
endinterface
`default_nettype wire

// File: rtl/lbm_stream_sequencer_dir_addr.sv
`default_nettype none
// ============================================================================
//  Module   : lbm_dir_addr
//  Purpose  : Combinational push-stream destination for one lattice
//             direction, with bounce-back and optional x wrap-around.
//  Ports    : i_x, i_y        source cell coordinates
//             i_cx, i_cy      direction velocity (-1..+1)
//             i_periodic_x    1 = wrap left/right edges
//             o_dest          destination cell index (own index on bounce)
//             o_bounce        destination left the domain, reflect in place
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module lbm_dir_addr
  import lbm_pkg::*;
#(
  parameter int NX = 16,
  parameter int NY = 16,
  parameter int AW = 8,
  parameter int XW = 4,
  parameter int YW = 4
) (
  input  wire logic [XW-1:0] i_x,
  input  wire logic [YW-1:0] i_y,
  input  wire vel_t          i_cx,
  input  wire vel_t          i_cy,
  input  wire logic          i_periodic_x,
  output logic [AW-1:0]      o_dest,
  output logic               o_bounce
);

  int w_nx;
  int w_ny;
  int w_dest;

  always_comb begin
    w_nx     = int'(i_x) + int'(i_cx);
    w_ny     = int'(i_y) + int'(i_cy);
    w_dest   = int'(i_y) * NX + int'(i_x);
    o_bounce = 1'b0;
    // y is never periodic, so a y escape bounces even when x would wrap.
    if (w_ny < 0 || w_ny >= NY) begin
      o_bounce = 1'b1;
    end else begin
      if (w_nx < 0 || w_nx >= NX) begin
        if (i_periodic_x) begin
          w_nx = (w_nx < 0) ? w_nx + NX : w_nx - NX;
        end else begin
          o_bounce = 1'b1;
        end
      end
      if (!o_bounce) begin
        w_dest = w_ny * NX + w_nx;
      end
    end
    o_dest = AW'(w_dest);
  end

endmodule
`default_nettype wire

// File: rtl/lbm_stream_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lbm_stream_sequencer
//  Purpose  : Sweeps an NX x NY D2Q9 grid for a programmable number of time
//             steps, emitting per cell the source address, all push-stream
//             destination addresses, bounce flags and wall/lid flags.
//  Ports    : Clk, Reset (async active-low)
//             start, num_steps, periodic_x   run control, latched at start
//             bus (master)                   cell word + valid/ready
//             buf_sel, time_count, busy, step_done, done   status
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module lbm_stream_sequencer
  import lbm_pkg::*;
#(
  parameter int NX               = 16,
  parameter int NY               = 16,
  parameter int Q                = 9,
  parameter int MAX_TIME         = 8,
  parameter int ADDRESS_WIDTH    = $clog2(NX*NY),
  parameter int ADDRESS_WIDTH2   = ADDRESS_WIDTH + 1,
  parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME+1)
) (
  input  wire logic                        Clk,
  input  wire logic                        Reset,
  input  wire logic                        start,
  input  wire logic [TIME_COUNT_WIDTH-1:0] num_steps,
  input  wire logic                        periodic_x,
  lbm_stream_sequencer_if.master           bus,
  output logic                             buf_sel,
  output logic [TIME_COUNT_WIDTH-1:0]      time_count,
  output logic                             busy,
  output logic                             step_done,
  output logic                             done
);

  localparam int c_XW  = (NX > 1) ? $clog2(NX) : 1;
  localparam int c_YW  = (NY > 1) ? $clog2(NY) : 1;
  localparam int c_AW2 = ADDRESS_WIDTH2;
  localparam logic [c_XW-1:0] c_X_LAST = c_XW'(NX - 1);
  localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(NY - 1);
  localparam logic [TIME_COUNT_WIDTH-1:0] c_MAX_T = TIME_COUNT_WIDTH'(MAX_TIME);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [c_XW-1:0]             r_x;
  logic [c_YW-1:0]             r_y;
  logic                        r_valid;
  logic [c_AW2-1:0]            r_cell_addr;
  logic [Q*c_AW2-1:0]          r_stream;
  logic [Q-1:0]                r_bounce;
  logic                        r_lid;
  logic                        r_bottom;
  logic                        r_left;
  logic                        r_right;
  logic                        r_buf;
  logic [TIME_COUNT_WIDTH-1:0] r_time;
  logic [TIME_COUNT_WIDTH-1:0] r_num;
  logic                        r_periodic;
  logic                        r_busy;
  logic                        r_step_done;
  logic                        r_done;

  logic                        w_hs;
  logic                        w_last_cell;
  logic [TIME_COUNT_WIDTH-1:0] w_num_clamped;
  logic                        w_valid_nxt;
  logic                        w_load;
  logic                        w_first;
  logic                        w_start_run;
  logic                        w_step_end;
  logic                        w_done_nxt;
  logic [c_XW-1:0]             w_x_nxt;
  logic [c_YW-1:0]             w_y_nxt;
  logic                        w_periodic_eff;
  logic [ADDRESS_WIDTH-1:0]    w_dest [Q];
  logic [Q-1:0]                w_bounce;
  logic [Q*c_AW2-1:0]          w_stream;

  assign w_hs          = r_valid & bus.ready_in;
  assign w_last_cell   = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
  assign w_num_clamped = (num_steps > c_MAX_T) ? c_MAX_T : num_steps;
  // The first cell is loaded in the same edge that latches periodic_x.
  assign w_periodic_eff = (r_state == IDLE) ? periodic_x : r_periodic;

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_load      = 1'b0;
    w_first     = 1'b0;
    w_start_run = 1'b0;
    w_step_end  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_run = 1'b1;
          if (w_num_clamped == '0) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = SWEEP;
            w_valid_nxt = 1'b1;
            w_load      = 1'b1;
            w_first     = 1'b1;
          end
        end
      end
      SWEEP: begin
        if (w_hs) begin
          if (w_last_cell) begin
            w_state_nxt = STEP_END;
            w_valid_nxt = 1'b0;
            w_step_end  = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      STEP_END: begin
        // r_time already holds the incremented count here.
        if (r_time == r_num) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = SWEEP;
          w_valid_nxt = 1'b1;
          w_load      = 1'b1;
          w_first     = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Coordinates of the word being loaded: (0,0) at step start, else raster advance.
  always_comb begin
    w_x_nxt = '0;
    w_y_nxt = '0;
    if (!w_first) begin
      if (r_x == c_X_LAST) begin
        w_y_nxt = r_y + c_YW'(1);
      end else begin
        w_x_nxt = r_x + c_XW'(1);
        w_y_nxt = r_y;
      end
    end
  end

  for (genvar i = 0; i < Q_D2Q9; i++) begin : g_dir
    lbm_dir_addr #(
      .NX (NX),
      .NY (NY),
      .AW (ADDRESS_WIDTH),
      .XW (c_XW),
      .YW (c_YW)
    ) u_dir (
      .i_x          (w_x_nxt),
      .i_y          (w_y_nxt),
      .i_cx         (CX[i]),
      .i_cy         (CY[i]),
      .i_periodic_x (w_periodic_eff),
      .o_dest       (w_dest[i]),
      .o_bounce     (w_bounce[i])
    );
    // Destinations are written into the opposite ping-pong buffer.
    assign w_stream[i*c_AW2 +: c_AW2] = {~r_buf, w_dest[i]};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_valid     <= 1'b0;
      r_cell_addr <= '0;
      r_stream    <= '0;
      r_bounce    <= '0;
      r_lid       <= 1'b0;
      r_bottom    <= 1'b0;
      r_left      <= 1'b0;
      r_right     <= 1'b0;
      r_buf       <= 1'b0;
      r_time      <= '0;
      r_num       <= '0;
      r_periodic  <= 1'b0;
      r_busy      <= 1'b0;
      r_step_done <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_valid     <= w_valid_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_step_done <= w_step_end;
      r_done      <= w_done_nxt;
      if (w_start_run) begin
        r_num      <= w_num_clamped;
        r_periodic <= periodic_x;
        r_time     <= '0;
      end
      if (w_step_end) begin
        r_time <= r_time + TIME_COUNT_WIDTH'(1);
        r_buf  <= ~r_buf;
      end
      if (w_load) begin
        r_x         <= w_x_nxt;
        r_y         <= w_y_nxt;
        r_cell_addr <= c_AW2'(mem_addr(r_buf, 32'(w_x_nxt), 32'(w_y_nxt),
                                       NX, ADDRESS_WIDTH));
        r_stream    <= w_stream;
        r_bounce    <= w_bounce;
        r_lid       <= (w_y_nxt == c_Y_LAST);
        r_bottom    <= (w_y_nxt == '0);
        r_left      <= !w_periodic_eff && (w_x_nxt == '0);
        r_right     <= !w_periodic_eff && (w_x_nxt == c_X_LAST);
      end
    end
  end

  assign bus.valid_out   = r_valid;
  assign bus.cell_addr   = r_cell_addr;
  assign bus.stream_addr = r_stream;
  assign bus.bounce      = r_bounce;
  assign bus.LID         = r_lid;
  assign bus.BOTTOM_WALL = r_bottom;
  assign bus.LEFT_WALL   = r_left;
  assign bus.RIGHT_WALL  = r_right;
  assign buf_sel         = r_buf;
  assign time_count      = r_time;
  assign busy            = r_busy;
  assign step_done       = r_step_done;
  assign done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lbm_stream_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lbm_stream_sequencer
//  Purpose  : Directed self-checking bench for lbm_stream_sequencer on a
//             16x16 grid: sweep order, ping-pong buffer, edge addressing,
//             stall stability, step clamp, async abort and zero-step run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lbm_stream_sequencer;

  localparam int c_NX  = 16;
  localparam int c_NY  = 16;
  localparam int c_AW2 = 9;
  localparam int c_TCW = 4;
  localparam int c_BUDGET = 4000;

  logic             Clk;
  logic             Reset;
  logic             start;
  logic [c_TCW-1:0] num_steps;
  logic             periodic_x;
  logic             buf_sel;
  logic [c_TCW-1:0] time_count;
  logic             busy;
  logic             step_done;
  logic             done;

  lbm_stream_sequencer_if #(.AW2(c_AW2), .Q(9)) bus ();

  lbm_stream_sequencer #(
    .NX(c_NX), .NY(c_NY), .Q(9), .MAX_TIME(8)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .num_steps  (num_steps),
    .periodic_x (periodic_x),
    .bus        (bus),
    .buf_sel    (buf_sel),
    .time_count (time_count),
    .busy       (busy),
    .step_done  (step_done),
    .done       (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Run observation results
  int   n_words, n_busy, n_sdone, n_done, seq_err, stall_err, valid_seen;
  logic m_buf;
  logic aborted;
  logic [9*c_AW2-1:0] s0_stream, s255_stream;
  logic [8:0]         s0_bounce, s255_bounce;
  logic [3:0]         s0_flags, s255_flags;

  function automatic logic [c_AW2-1:0] sa(input logic [9*c_AW2-1:0] v, input int i);
    return v[i*c_AW2 +: c_AW2];
  endfunction

  task automatic do_run(input logic [c_TCW-1:0] n, input logic per,
                        input int stall_idx, input int abort_idx);
    int   exp_idx;
    logic stalled;
    logic finished;
    logic [c_AW2-1:0]   h_cell;
    logic [9*c_AW2-1:0] h_stream;
    logic [8:0]         h_bounce;
    n_words = 0; n_busy = 0; n_sdone = 0; n_done = 0;
    seq_err = 0; stall_err = 0; valid_seen = 0;
    aborted = 1'b0; finished = 1'b0; stalled = 1'b0; exp_idx = 0;
    @(negedge Clk);
    num_steps = n; periodic_x = per; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    // Changes after start must not matter
    periodic_x = ~per; num_steps = 4'd3;
    for (int c = 0; c < c_BUDGET; c++) begin
      if (busy && !done) n_busy++;
      if (step_done) begin
        n_sdone++;
        m_buf   = ~m_buf;
        exp_idx = 0;
        check_val("buf_at_step", {63'd0, buf_sel}, {63'd0, m_buf});
      end
      if (done) begin
        n_done++;
        finished = 1'b1;
        break;
      end
      if (bus.valid_out) begin
        valid_seen++;
        if (exp_idx == abort_idx) begin
          Reset = 1'b0;
          #1;
          check_val("abort_valid", {63'd0, bus.valid_out}, 64'd0);
          check_val("abort_cell", {55'd0, bus.cell_addr}, 64'd0);
          check_val("abort_stream_zero", {63'd0, (bus.stream_addr == '0)}, 64'd1);
          check_val("abort_misc", {52'd0, bus.bounce, bus.LID, bus.BOTTOM_WALL, bus.LEFT_WALL, bus.RIGHT_WALL},
                    64'd0);
          check_val("abort_status", {56'd0, buf_sel, time_count, busy, step_done, done}, 64'd0);
          aborted = 1'b1;
          m_buf   = 1'b0;
          break;
        end
        if (exp_idx == stall_idx && !stalled) begin
          stalled  = 1'b1;
          h_cell   = bus.cell_addr;
          h_stream = bus.stream_addr;
          h_bounce = bus.bounce;
          bus.ready_in = 1'b0;
          for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            if (bus.cell_addr != h_cell || bus.stream_addr != h_stream ||
                bus.bounce != h_bounce || !bus.valid_out) stall_err++;
          end
          bus.ready_in = 1'b1;
        end
        if (bus.ready_in) begin
          if (bus.cell_addr != {m_buf, 8'(exp_idx)}) seq_err++;
          if (n_sdone == 0 && exp_idx == 0) begin
            s0_stream = bus.stream_addr; s0_bounce = bus.bounce;
            s0_flags  = {bus.LID, bus.BOTTOM_WALL, bus.LEFT_WALL, bus.RIGHT_WALL};
          end
          if (n_sdone == 0 && exp_idx == 255) begin
            s255_stream = bus.stream_addr; s255_bounce = bus.bounce;
            s255_flags  = {bus.LID, bus.BOTTOM_WALL, bus.LEFT_WALL, bus.RIGHT_WALL};
          end
          exp_idx++;
          n_words++;
        end
      end
      @(negedge Clk);
    end
    if (!finished && !aborted) check_val("run_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int done_seen;
    Reset = 1'b0; start = 1'b0; num_steps = '0; periodic_x = 1'b0;
    bus.ready_in = 1'b1;
    m_buf = 1'b0;
    repeat (2) @(negedge Clk);
    check_val("rst_valid", {63'd0, bus.valid_out}, 64'd0);
    check_val("rst_cell", {55'd0, bus.cell_addr}, 64'd0);
    check_val("rst_bounce_flags", {51'd0, bus.bounce, bus.LID, bus.BOTTOM_WALL, bus.LEFT_WALL, bus.RIGHT_WALL},
              64'd0);
    check_val("rst_status", {56'd0, buf_sel, time_count, busy, step_done, done}, 64'd0);
    Reset = 1'b1;

    // Run A: walls, two steps, ready always high
    do_run(4'd2, 1'b0, -1, -1);
    check_val("A_words", 64'(n_words), 64'd512);
    check_val("A_busy_cycles", 64'(n_busy), 64'd514);
    check_val("A_step_done", 64'(n_sdone), 64'd2);
    check_val("A_done", 64'(n_done), 64'd1);
    check_val("A_seq_err", 64'(seq_err), 64'd0);
    check_val("A_time_count", 64'(time_count), 64'd2);
    check_val("A_buf_sel", {63'd0, buf_sel}, 64'd0);
    check_val("A_c0_s1", 64'(sa(s0_stream, 1)), 64'd257);
    check_val("A_c0_s2", 64'(sa(s0_stream, 2)), 64'd272);
    check_val("A_c0_s3", 64'(sa(s0_stream, 3)), 64'd256);
    check_val("A_c0_bounce", 64'(s0_bounce), 64'b111011000);
    check_val("A_c0_flags", 64'(s0_flags), 64'b0110);
    check_val("A_c255_flags", 64'(s255_flags), 64'b1001);
    check_val("A_c255_s5", 64'(sa(s255_stream, 5)), 64'd511);
    check_val("A_c255_b5", 64'(s255_bounce[5]), 64'd1);
    check_val("A_c255_s4", 64'(sa(s255_stream, 4)), 64'd495);
    check_val("A_c255_b4", 64'(s255_bounce[4]), 64'd0);
    @(negedge Clk);
    check_val("A_idle_busy", {63'd0, busy}, 64'd0);

    // Run B: periodic x, one step, stall at cell 5
    do_run(4'd1, 1'b1, 5, -1);
    check_val("B_words", 64'(n_words), 64'd256);
    check_val("B_seq_err", 64'(seq_err), 64'd0);
    check_val("B_stall_err", 64'(stall_err), 64'd0);
    check_val("B_c0_s3", 64'(sa(s0_stream, 3)), 64'd271);
    check_val("B_c0_s6", 64'(sa(s0_stream, 6)), 64'd287);
    check_val("B_c0_bounce", 64'(s0_bounce), 64'b110010000);
    check_val("B_c0_flags", 64'(s0_flags), 64'b0100);
    check_val("B_c255_flags", 64'(s255_flags), 64'b1000);
    check_val("B_buf_sel", {63'd0, buf_sel}, 64'd1);

    // Run C: request above MAX_TIME clamps to 8 steps
    do_run(4'd15, 1'b0, -1, -1);
    check_val("C_step_done", 64'(n_sdone), 64'd8);
    check_val("C_time_count", 64'(time_count), 64'd8);
    check_val("C_seq_err", 64'(seq_err), 64'd0);

    // Run D: asynchronous reset at cell 7, no done afterwards
    do_run(4'd1, 1'b0, -1, 7);
    check_val("D_aborted", {63'd0, aborted}, 64'd1);
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      if (done) done_seen++;
    end
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      if (done || busy) done_seen++;
    end
    check_val("D_no_done", 64'(done_seen), 64'd0);

    // Run E: zero steps goes straight to DONE
    do_run(4'd0, 1'b0, -1, -1);
    check_val("E_done", 64'(n_done), 64'd1);
    check_val("E_valid_seen", 64'(valid_seen), 64'd0);
    check_val("E_step_done", 64'(n_sdone), 64'd0);
    check_val("E_time_count", 64'(time_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
